reflet_float_sequencer: RTL
===========================

Name: reflet_float_sequencer

Overview:
- Command front-end and initiator for the reflet FPU arithmetic unit.
- Holds a small float register file and accepts load, read and operate commands from the CPU side over a valid/ready handshake.
- For operate commands it drives the AU enable, opcode and operand buses, then holds enable until the AU asserts ready.
- It writes the AU result back to the register file and returns a response with result, flag and error.

Parameters:
- float_size, 32, width of every float word.
- reg_count, 8, number of float registers (power of two, at least 2); idx_w = $clog2(reg_count).
- timeout, 64, maximum number of EXEC cycles spent waiting for au_ready before the command is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_kind  in  2  00 operate, 01 load register, 10 read register, 11 reserved.
- cmd_opcode  in  6  AU opcode (OPP_* values from reflet_fpu.vh), passed through unchanged.
- cmd_dst  in  idx_w  destination register.
- cmd_src1  in  idx_w  source register 1.
- cmd_src2  in  idx_w  source register 2.
- cmd_src3  in  idx_w  source register 3.
- cmd_data  in  float_size  load value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  float_size  result, loaded value or read value.
- rsp_flag  out  1  AU flag captured with the result.
- rsp_error  out  1  timeout or reserved command.
- au_enable  out  1  AU enable.
- au_opcode  out  6  AU opcode.
- au_in1  out  float_size  AU operand 1.
- au_in2  out  float_size  AU operand 2.
- au_in3  out  float_size  AU operand 3.
- au_out  in  float_size  AU result.
- au_flag  in  1  AU flag.
- au_ready  in  1  AU result valid.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - State goes to IDLE.
  - All registers, au_* outputs, rsp_* outputs and the timeout counter go to 0.
  - cmd_ready is 1 after reset.
- States and transitions:
  - IDLE: cmd_ready=1, au_enable=0. A command is accepted on the edge where cmd_valid & cmd_ready.
  - Accepted kind 01 (load): reg[cmd_dst] <= cmd_data; rsp_data <= cmd_data; rsp_error <= 0; go to RESP.
  - Accepted kind 10 (read): rsp_data <= reg[cmd_src1]; go to RESP.
  - Accepted kind 11 (reserved): rsp_error <= 1; rsp_data <= 0; no register change; go to RESP.
  - Accepted kind 00 (operate):
    - Latch au_opcode <= cmd_opcode; au_in1/2/3 <= reg[src1/2/3], sampled at the accept edge.
    - Latch the destination index; clear the counter; go to EXEC.
  - EXEC: au_enable=1; au_opcode and au_in* are held stable; the counter increments each cycle.
  - EXEC, au_ready=1 sampled on an edge:
    - reg[dst] <= au_out; rsp_data <= au_out; rsp_flag <= au_flag; rsp_error <= 0; go to RESP.
    - au_ready is honoured even when it is asserted in the first EXEC cycle, because combinational-ready ops such as ADD and SUB give zero extra latency.
  - EXEC, timeout: when the counter reaches timeout-1 with au_ready low:
    - rsp_error <= 1; no writeback; go to RESP.
    - If au_ready and timeout occur in the same cycle, ready wins.
  - RESP: rsp_valid=1, au_enable=0; rsp_* are held stable until rsp_ready, then go to IDLE.
- AU enable rule: au_enable is low for at least 2 cycles (RESP plus IDLE) between consecutive operations. The AU's multi-cycle primitives restart on an enable rising edge, and dropping enable is the only abort mechanism.
- Latency:
  - Load, read or reserved command: accept edge to rsp_valid is 1 cycle.
  - Operate: accept edge to rsp_valid is N+1 cycles, where N ≥ 1 is the EXEC cycle at which au_ready is seen.
- Hazards:
  - dst equal to a src is legal; the operand snapshot was taken at accept, so the result overwrites cleanly.
  - No command is accepted outside IDLE, so no RAW hazard exists.
- rsp_flag is cleared to 0 for load, read and reserved commands.
- Reset during EXEC drops au_enable in the same cycle and suppresses the writeback.
- Index widths are exact; out-of-range indices are impossible by construction.

Test Plan:
- Reset then load: after reset, load 0x3F800000 (1.0) into r1 and 0x40000000 (2.0) into r2 -> each rsp_valid arrives 1 cycle after accept with the data echoed and rsp_error=0. Reading r1 returns 0x3F800000, and reading r0 returns 0.
- Zero-latency op: bench AU model asserts au_ready combinationally. Operate OPP_ADD, dst=r3, src1=r1, src2=r2, with the model returning 0x40400000 -> au_enable is high exactly 1 cycle, r3=0x40400000, rsp_valid arrives 2 cycles after accept.
- Multi-cycle op: model asserts ready 5 cycles after the enable rise. Operate OPP_MUL, dst=r1, src1=r1, src2=r2 -> au_in1=0x3F800000 and au_in2=0x40000000 are stable for all 5 EXEC cycles, r1 becomes au_out, rsp_flag equals au_flag, and a back-to-back command shows au_enable low for ≥2 cycles.
- Timeout and stalled response:
  - Model never asserts ready, timeout=64 -> exactly 64 EXEC cycles, then rsp_error=1 with dst unchanged.
  - Holding rsp_ready=0 for 10 cycles keeps rsp_* stable and cmd_ready=0.
- Ready at boundary and reserved kind:
  - Ready asserted exactly at counter=63 -> writeback occurs and rsp_error=0.
  - cmd_kind=11 -> rsp_error=1 and no register changes.
- Reset mid-EXEC: assert reset 3 cycles into a 5-cycle op -> au_enable falls in the same cycle, all registers read 0 afterwards, and no response is emitted.

Source files
------------

// File: rtl/reflet_float_sequencer.sv
// reflet_float_sequencer: command front-end and initiator for the reflet FPU AU.
// Ports: cmd_* command handshake in, rsp_* response handshake out,
//        au_* drive/observe the arithmetic unit, busy flags a non-IDLE state.
module reflet_float_sequencer #(
    parameter int float_size = 32,
    parameter int reg_count  = 8,
    parameter int timeout    = 64,
    localparam int idx_w     = $clog2(reg_count)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_kind,
    input  logic [5:0]            cmd_opcode,
    input  logic [idx_w-1:0]      cmd_dst,
    input  logic [idx_w-1:0]      cmd_src1,
    input  logic [idx_w-1:0]      cmd_src2,
    input  logic [idx_w-1:0]      cmd_src3,
    input  logic [float_size-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [float_size-1:0] rsp_data,
    output logic                  rsp_flag,
    output logic                  rsp_error,
    output logic                  au_enable,
    output logic [5:0]            au_opcode,
    output logic [float_size-1:0] au_in1,
    output logic [float_size-1:0] au_in2,
    output logic [float_size-1:0] au_in3,
    input  logic [float_size-1:0] au_out,
    input  logic                  au_flag,
    input  logic                  au_ready,
    output logic                  busy
);
    localparam int cnt_w = $clog2(timeout + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [float_size-1:0] regs [reg_count];
    logic [idx_w-1:0]      dst_q;
    logic [cnt_w-1:0]      cnt;
    logic                  accept;
    logic                  expired;

    assign accept  = cmd_valid && cmd_ready;
    assign expired = (cnt == cnt_w'(timeout - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // au_ready has priority over the timeout in the last EXEC cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cmd_valid)
                state_nx = (cmd_kind == 2'b00) ? EXEC : RESP;
            EXEC: if (au_ready || expired)
                state_nx = RESP;
            RESP: if (rsp_ready)
                state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // au_enable is decoded from the state so an async reset drops it at once
    always_comb begin
        cmd_ready = 1'b0;
        au_enable = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            EXEC:    au_enable = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < reg_count; i++)
                regs[i] <= '0;
            dst_q     <= '0;
            cnt       <= '0;
            au_opcode <= '0;
            au_in1    <= '0;
            au_in2    <= '0;
            au_in3    <= '0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            rsp_error <= 1'b0;
        end else begin
            unique case (1'b1)
                accept: begin
                    cnt <= '0;
                    unique case (cmd_kind)
                        2'b00: begin
                            au_opcode <= cmd_opcode;
                            au_in1    <= regs[cmd_src1];
                            au_in2    <= regs[cmd_src2];
                            au_in3    <= regs[cmd_src3];
                            dst_q     <= cmd_dst;
                        end
                        2'b01: begin
                            regs[cmd_dst] <= cmd_data;
                            rsp_data      <= cmd_data;
                            rsp_flag      <= 1'b0;
                            rsp_error     <= 1'b0;
                        end
                        2'b10: begin
                            rsp_data  <= regs[cmd_src1];
                            rsp_flag  <= 1'b0;
                            rsp_error <= 1'b0;
                        end
                        default: begin
                            rsp_data  <= '0;
                            rsp_flag  <= 1'b0;
                            rsp_error <= 1'b1;
                        end
                    endcase
                end
                au_enable: begin
                    cnt <= cnt + cnt_w'(1);
                    if (au_ready) begin
                        regs[dst_q] <= au_out;
                        rsp_data    <= au_out;
                        rsp_flag    <= au_flag;
                        rsp_error   <= 1'b0;
                    end else if (expired) begin
                        rsp_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
